arf192b080e1r1w0cbbehbaa4acw_rcb_ctl: RTL and testbench

- Enable-side controller for the array's per-bank write-clock gaters. It produces the en/fd/rd inputs those gaters consume.
- Decodes accepted write requests to a bank and holds that bank's gate enable open for a hysteresis window.
- Sequences a force-disable (power-down) handshake through a RUN/DRAIN/OFF state machine.
- Sits between the write-port pipeline and the bank clock gaters. All outputs are flop-driven, so they are stable before the gater's clkb-low transparent phase.

---
 rtl/arf192b080e1r1w0cbbehbaa4acw_rcb_ctl_pkg.sv | 31 +++
 rtl/arf192b080e1r1w0cbbehbaa4acw_rcb_hyst.sv | 42 ++++
 rtl/arf192b080e1r1w0cbbehbaa4acw_rcb_ctl.sv | 93 +++++++++
 tb/tb_arf192b080e1r1w0cbbehbaa4acw_rcb_ctl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arf192b080e1r1w0cbbehbaa4acw_rcb_ctl_pkg.sv
// Shared types and constants for the bank write-clock enable controller.
package arf192b080e1r1w0cbbehbaa4acw_rcb_ctl_pkg;

  localparam int ENTRIES      = 192;
  localparam int NUM_BANKS    = 8;
  localparam int ENT_PER_BANK = ENTRIES / NUM_BANKS;
  localparam int ADDR_W       = 8;
  localparam int CNT_W        = 4;

  typedef logic [2:0]       bank_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    OFF
  } state_t;

  // Map an entry address to its bank with a chain of threshold compares,
  // so no divider is built. Out-of-range addresses land in the last bank
  // and must be filtered by the caller.
  function automatic bank_t bank_of(input logic [ADDR_W-1:0] addr);
    bank_t bank;
    bank = '0;
    for (int b = 1; b < NUM_BANKS; b++) begin
      if (int'(addr) >= b * ENT_PER_BANK) bank = bank_t'(b);
    end
    return bank;
  endfunction

endpackage

// File: rtl/arf192b080e1r1w0cbbehbaa4acw_rcb_hyst.sv
// One bank's hysteresis counter and its registered gate enable.
module arf192b080e1r1w0cbbehbaa4acw_rcb_hyst
  import arf192b080e1r1w0cbbehbaa4acw_rcb_ctl_pkg::*;
#(
  parameter int HYST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic dft_force_on,
  output logic en,
  output logic idle
);

  cnt_t cnt;
  cnt_t cnt_next;

  // Reload on a write to this bank, otherwise count down to zero and stop.
  always_comb begin
    cnt_next = cnt;
    if (hit) begin
      cnt_next = cnt_t'(HYST);
    end else if (cnt != '0) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // Enable is its own flop driven from the next count, so it rises the
  // cycle after the write and is glitch-free at the gater input.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      en  <= 1'b0;
    end else begin
      cnt <= cnt_next;
      en  <= (cnt_next != '0) | dft_force_on;
    end
  end

  assign idle = (cnt == '0);

endmodule

// File: rtl/arf192b080e1r1w0cbbehbaa4acw_rcb_ctl.sv
// Enable-side controller for the per-bank write-clock gaters: decodes
// accepted writes into per-bank enable windows and sequences the
// force-disable handshake through RUN / DRAIN / OFF.
module arf192b080e1r1w0cbbehbaa4acw_rcb_ctl
  import arf192b080e1r1w0cbbehbaa4acw_rcb_ctl_pkg::*;
#(
  parameter int HYST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_vld,
  input  logic [ADDR_W-1:0]    wr_addr,
  output logic                 wr_rdy,
  output logic                 addr_err,
  input  logic                 fd_req,
  output logic                 fd_ack,
  input  logic                 dft_force_on,
  output logic [NUM_BANKS-1:0] rcb_en,
  output logic                 rcb_fd,
  output logic                 rcb_rd
);

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 in_range;
  logic                 all_idle;
  bank_t                bank;
  logic [NUM_BANKS-1:0] bank_hit;
  logic [NUM_BANKS-1:0] bank_idle;

  assign accept   = wr_vld & wr_rdy;
  assign in_range = (wr_addr < ADDR_W'(ENTRIES));
  assign bank     = bank_of(wr_addr);
  assign all_idle = &bank_idle;

  // One-hot strobe to the bank addressed by an accepted, in-range write.
  always_comb begin
    bank_hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_hit[b] = accept & in_range & (bank == bank_t'(b));
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    arf192b080e1r1w0cbbehbaa4acw_rcb_hyst #(
      .HYST (HYST)
    ) u_hyst (
      .clk          (clk),
      .rst          (rst),
      .hit          (bank_hit[g]),
      .dft_force_on (dft_force_on),
      .en           (rcb_en[g]),
      .idle         (bank_idle[g])
    );
  end

  // Power-down sequencing: DRAIN waits for every open bank window to close
  // before reporting OFF; dropping the request returns to RUN from anywhere.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (fd_req) state_next = DRAIN;
      DRAIN: begin
        if (!fd_req)       state_next = RUN;
        else if (all_idle) state_next = OFF;
      end
      OFF:     if (!fd_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // State and handshake outputs are registered from the next state; the
  // DFT override masks the force-disable one cycle after it is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wr_rdy   <= 1'b0;
      fd_ack   <= 1'b0;
      rcb_fd   <= 1'b0;
      rcb_rd   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_next;
      wr_rdy   <= (state_next == RUN);
      fd_ack   <= (state_next == OFF);
      rcb_fd   <= (state_next == OFF) & ~dft_force_on;
      rcb_rd   <= dft_force_on;
      addr_err <= accept & ~in_range;
    end
  end

endmodule

// File: tb/tb_arf192b080e1r1w0cbbehbaa4acw_rcb_ctl.sv
// Self-checking bench for the bank write-clock enable controller.
module tb_arf192b080e1r1w0cbbehbaa4acw_rcb_ctl;
  import arf192b080e1r1w0cbbehbaa4acw_rcb_ctl_pkg::*;

  localparam int HYST = 4;

  logic       clk;
  logic       rst;
  logic       wr_vld;
  logic [7:0] wr_addr;
  logic       wr_rdy;
  logic       addr_err;
  logic       fd_req;
  logic       fd_ack;
  logic       dft_force_on;
  logic [7:0] rcb_en;
  logic       rcb_fd;
  logic       rcb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  arf192b080e1r1w0cbbehbaa4acw_rcb_ctl #(
    .HYST (HYST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_vld       (wr_vld),
    .wr_addr      (wr_addr),
    .wr_rdy       (wr_rdy),
    .addr_err     (addr_err),
    .fd_req       (fd_req),
    .fd_ack       (fd_ack),
    .dft_force_on (dft_force_on),
    .rcb_en       (rcb_en),
    .rcb_fd       (rcb_fd),
    .rcb_rd       (rcb_rd)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each bank remembers the cycle of its last write and is
  // enabled for the HYST cycles that follow it; power-down is tracked with
  // two flags (draining, off).
  int   cyc = 0;
  int   last_hit [NUM_BANKS];
  bit   m_drain = 0;
  bit   m_off   = 0;
  logic m_rdy = 0, m_err = 0, m_ack = 0, m_fd = 0, m_rd = 0;
  logic [7:0] m_en = '0;

  initial for (int i = 0; i < NUM_BANKS; i++) last_hit[i] = -1000;

  function automatic bit in_window(input int b, input int t);
    return (t - last_hit[b] >= 1) && (t - last_hit[b] <= HYST);
  endfunction

  task automatic modelStep();
    bit idle_now;
    bit acc;
    idle_now = 1;
    for (int b = 0; b < NUM_BANKS; b++) if (in_window(b, cyc)) idle_now = 0;
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) last_hit[b] = -1000;
      m_drain = 0; m_off = 0;
      m_rdy = 0; m_err = 0; m_ack = 0; m_fd = 0; m_rd = 0; m_en = '0;
    end else begin
      acc   = wr_vld && m_rdy;
      m_err = acc && (int'(wr_addr) >= ENTRIES);
      if (acc && int'(wr_addr) < ENTRIES) last_hit[int'(wr_addr) / ENT_PER_BANK] = cyc;
      if (m_off) begin
        if (!fd_req) m_off = 0;
      end else if (m_drain) begin
        if (!fd_req) m_drain = 0;
        else if (idle_now) begin m_drain = 0; m_off = 1; end
      end else if (fd_req) begin
        m_drain = 1;
      end
      m_rdy = !m_drain && !m_off;
      m_ack = m_off;
      m_fd  = m_off && !dft_force_on;
      m_rd  = dft_force_on;
      for (int b = 0; b < NUM_BANKS; b++) m_en[b] = in_window(b, cyc + 1) || dft_force_on;
    end
    cyc++;
  endtask

  // Drive one cycle of inputs, advance the model, then sample at the falling edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] a,
                               input logic f, input logic d);
    rst = r; wr_vld = v; wr_addr = a; fd_req = f; dft_force_on = d;
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic e_rdy, input logic e_err,
                             input logic e_ack, input logic [7:0] e_en,
                             input logic e_fd, input logic e_rd);
    logic [12:0] act, exp;
    act = {wr_rdy, addr_err, fd_ack, rcb_en, rcb_fd, rcb_rd};
    exp = {e_rdy, e_err, e_ack, e_en, e_fd, e_rd};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d got rdy/err/ack/en/fd/rd=%b/%b/%b/%h/%b/%b expected %b/%b/%b/%h/%b/%b",
               name, cyc, wr_rdy, addr_err, fd_ack, rcb_en, rcb_fd, rcb_rd,
               e_rdy, e_err, e_ack, e_en, e_fd, e_rd);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_rdy, m_err, m_ack, m_en, m_fd, m_rd);
  endtask

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] addr;
    logic       fd;
    logic       dft;
    logic       e_rdy;
    logic       e_err;
    logic       e_ack;
    logic [7:0] e_en;
    logic       e_fd;
    logic       e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void pushVec(input logic r, input logic v, input logic [7:0] a,
                                  input logic rdy, input logic [7:0] en);
    vec_t t;
    t.rst = r; t.vld = v; t.addr = a; t.fd = 1'b0; t.dft = 1'b0;
    t.e_rdy = rdy; t.e_err = 1'b0; t.e_ack = 1'b0; t.e_en = en; t.e_fd = 1'b0; t.e_rd = 1'b0;
    vecs.push_back(t);
  endfunction

  initial begin
    logic [7:0] waddr [3];
    logic [7:0] wmask [3];
    logic       fd_lvl;
    logic       dft_lvl;
    logic       r;
    logic       v;
    logic [7:0] a;
    logic [7:0] e_en;
    logic       d;

    rst = 1'b1; wr_vld = 1'b0; wr_addr = '0; fd_req = 1'b0; dft_force_on = 1'b0;

    // Reset and bank-decode table: each row's outputs are those seen in the next cycle.
    waddr[0] = 8'd0;   wmask[0] = 8'h01;
    waddr[1] = 8'd47;  wmask[1] = 8'h02;
    waddr[2] = 8'd191; wmask[2] = 8'h80;
    for (int i = 0; i < 3; i++) pushVec(1'b1, 1'b0, 8'd0, 1'b0, 8'h00);
    pushVec(1'b0, 1'b0, 8'd0, 1'b1, 8'h00);
    pushVec(1'b0, 1'b0, 8'd0, 1'b1, 8'h00);
    for (int w = 0; w < 3; w++) begin
      pushVec(1'b0, 1'b1, waddr[w], 1'b1, wmask[w]);
      for (int i = 0; i < 3; i++) pushVec(1'b0, 1'b0, 8'd0, 1'b1, wmask[w]);
      for (int i = 0; i < 6; i++) pushVec(1'b0, 1'b0, 8'd0, 1'b1, 8'h00);
    end

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].addr, vecs[i].fd, vecs[i].dft);
      checkOutput("table", vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_ack,
                  vecs[i].e_en, vecs[i].e_fd, vecs[i].e_rd);
    end

    // Window extension on bank 1 and an out-of-range write at cycle 10.
    for (int c = 0; c <= 12; c++) begin
      v = (c == 0) || (c == 3) || (c == 10);
      a = (c == 10) ? 8'd192 : 8'd30;
      applyStimulus(1'b0, v, a, 1'b0, 1'b0);
      checkOutput("extend", 1'b1, (c == 10), 1'b0, (c <= 6) ? 8'h02 : 8'h00, 1'b0, 1'b0);
      checkModel("extend_model");
    end

    // Power-down with a write in the request cycle, DFT pulse while OFF, then release.
    for (int c = 0; c <= 22; c++) begin
      d = (c == 10) || (c == 11);
      applyStimulus(1'b0, (c == 0), 8'd100, (c < 20), d);
      if (d)          e_en = 8'hFF;
      else if (c < 4) e_en = 8'h10;
      else            e_en = 8'h00;
      checkOutput("powerdown", (c >= 20), 1'b0, (c >= 5 && c < 20), e_en,
                  (c >= 5 && c < 20 && !d), d);
    end

    // Reset while bank 2's window is open.
    for (int c = 0; c <= 5; c++) begin
      applyStimulus((c == 2), (c == 0), 8'd60, 1'b0, 1'b0);
      checkOutput("rst_mid", (c != 2), 1'b0, 1'b0, (c < 2) ? 8'h04 : 8'h00, 1'b0, 1'b0);
    end

    // Randomized traffic against the reference model.
    fd_lvl  = 1'b0;
    dft_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) fd_lvl = ~fd_lvl;
      if ($urandom_range(40) == 0) dft_lvl = ~dft_lvl;
      r = ($urandom_range(199) == 0);
      v = ($urandom_range(2) != 0);
      a = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 192)) : 8'($urandom_range(191));
      applyStimulus(r, v, a, fd_lvl, dft_lvl);
      checkModel("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
